// File: rtl/arp_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : arp_sequencer
//  Brief    : Arpeggiator note scheduler. Holds a chord table of DDS phase
//             increments and steps through it in UP / DOWN / UP-DOWN / RANDOM
//             order, advancing once every note_dur sample ticks.
//  Options  : define ARP_GATE_EN to add the gate_len input and gate output
//             (staccato gating of delta within each step).
//  Revision : 1.0 - initial release
// ============================================================================
module arp_sequencer #(
   parameter int PHASE_WIDTH = 32,
   parameter int MAX_NOTES   = 4,
   parameter int DUR_WIDTH   = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         sample_tick,
   input  logic                         run,
   input  logic [1:0]                   pattern,
   input  logic [$clog2(MAX_NOTES):0]   num_notes,
   input  logic [DUR_WIDTH-1:0]         note_dur,
   input  logic                         wr_en,
   input  logic [$clog2(MAX_NOTES)-1:0] wr_addr,
   input  logic [PHASE_WIDTH-1:0]       wr_delta,
`ifdef ARP_GATE_EN
   input  logic [DUR_WIDTH-1:0]         gate_len,
   output logic                         gate,
`endif
   output logic [PHASE_WIDTH-1:0]       delta,
   output logic [$clog2(MAX_NOTES)-1:0] note_index,
   output logic                         step_strobe
);

   localparam int AW = $clog2(MAX_NOTES);
   localparam int NW = AW + 1;

   localparam logic [1:0] PAT_UP     = 2'd0;
   localparam logic [1:0] PAT_DOWN   = 2'd1;
   localparam logic [1:0] PAT_UPDOWN = 2'd2;
   localparam logic [1:0] PAT_RANDOM = 2'd3;

   localparam logic [15:0] LFSR_SEED = 16'hACE1;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      PLAY = 1'b1
   } state_t;

   state_t                  state;
   logic [PHASE_WIDTH-1:0]  chord [MAX_NOTES];
   logic [DUR_WIDTH-1:0]    cnt;
   logic [15:0]             lfsr;
   logic                    dir_up;

   logic [NW-1:0]           num_eff;
   logic [AW-1:0]           last_idx;
   logic [DUR_WIDTH-1:0]    dur_m1;
   logic                    step_due;
   logic [15:0]             lfsr_next;
   logic [15:0]             rand_div;
   logic [AW-1:0]           rand_idx;
   logic                    in_range;
   logic [AW-1:0]           next_idx;
   logic                    next_dir_up;
   logic [AW-1:0]           first_idx;
   logic [AW-1:0]           load_idx;
   logic [PHASE_WIDTH-1:0]  load_val;
`ifdef ARP_GATE_EN
   logic                    gate_closes;
`endif

   // Derived controls: clamped note count, step boundary, next index per pattern
   always_comb begin
      num_eff     = (num_notes > NW'(MAX_NOTES)) ? NW'(MAX_NOTES) : num_notes;
      last_idx    = AW'(num_eff - 1'b1);
      dur_m1      = (note_dur == '0) ? '0 : (note_dur - 1'b1);
      step_due    = sample_tick && (cnt >= dur_m1);
      lfsr_next   = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
      rand_div    = (num_eff == '0) ? 16'd1 : 16'(num_eff);
      rand_idx    = AW'(lfsr_next % rand_div);
      in_range    = ({1'b0, note_index} < num_eff);
      next_idx    = '0;
      next_dir_up = dir_up;

      case (pattern)
         PAT_UP: begin
            if (in_range && (note_index != last_idx))
               next_idx = AW'(note_index + 1'b1);
         end
         PAT_DOWN: begin
            if (!in_range || (note_index == '0))
               next_idx = last_idx;
            else
               next_idx = AW'(note_index - 1'b1);
         end
         PAT_UPDOWN: begin
            // Bounce without repeating endpoints; a lone note stays at 0
            if (!in_range || (num_eff == NW'(1))) begin
               next_idx    = '0;
               next_dir_up = 1'b1;
            end else if (dir_up) begin
               if (note_index == last_idx) begin
                  next_idx    = AW'(note_index - 1'b1);
                  next_dir_up = 1'b0;
               end else begin
                  next_idx    = AW'(note_index + 1'b1);
               end
            end else begin
               if (note_index == '0) begin
                  next_idx    = AW'(1);
                  next_dir_up = 1'b1;
               end else begin
                  next_idx    = AW'(note_index - 1'b1);
               end
            end
         end
         default: begin
            next_idx = rand_idx;
         end
      endcase

      first_idx = (pattern == PAT_DOWN) ? last_idx : '0;
      load_idx  = (state == IDLE) ? first_idx : next_idx;
      // Write-first: a write to the slot being loaded wins over the stored value
      load_val  = (wr_en && (wr_addr == load_idx)) ? wr_delta : chord[load_idx];
`ifdef ARP_GATE_EN
      gate_closes = (gate_len != '0) && (gate_len <= dur_m1) &&
                    (DUR_WIDTH'(cnt + 1'b1) >= gate_len);
`endif
   end

   // Chord table storage, writable in any state
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < MAX_NOTES; i++)
            chord[i] <= '0;
      end else if (wr_en && (32'(wr_addr) < MAX_NOTES)) begin
         chord[wr_addr] <= wr_delta;
      end
   end

   // Sequencer FSM with registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         delta       <= '0;
         note_index  <= '0;
         step_strobe <= 1'b0;
         cnt         <= '0;
         lfsr        <= LFSR_SEED;
         dir_up      <= 1'b1;
`ifdef ARP_GATE_EN
         gate        <= 1'b0;
`endif
      end else begin
         step_strobe <= 1'b0;
         case (state)
            IDLE: begin
               delta      <= '0;
               note_index <= '0;
               cnt        <= '0;
`ifdef ARP_GATE_EN
               gate       <= 1'b0;
`endif
               if (run && (num_eff != '0)) begin
                  state       <= PLAY;
                  delta       <= load_val;
                  note_index  <= load_idx;
                  step_strobe <= 1'b1;
                  dir_up      <= 1'b1;
`ifdef ARP_GATE_EN
                  gate        <= 1'b1;
`endif
               end
            end
            PLAY: begin
               if (!run || (num_eff == '0)) begin
                  state      <= IDLE;
                  delta      <= '0;
                  note_index <= '0;
                  cnt        <= '0;
`ifdef ARP_GATE_EN
                  gate       <= 1'b0;
`endif
               end else if (sample_tick) begin
                  if (step_due) begin
                     cnt         <= '0;
                     delta       <= load_val;
                     note_index  <= load_idx;
                     step_strobe <= 1'b1;
                     dir_up      <= next_dir_up;
                     if (pattern == PAT_RANDOM)
                        lfsr <= lfsr_next;
`ifdef ARP_GATE_EN
                     gate        <= 1'b1;
`endif
                  end else begin
                     cnt <= cnt + 1'b1;
`ifdef ARP_GATE_EN
                     if (gate_closes) begin
                        delta <= '0;
                        gate  <= 1'b0;
                     end
`endif
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire
